// File: rtl/fft_stream_source.sv
// Programmable frame generator (ramp / constant / impulse / LFSR) with valid/ready back-pressure.
// Define STREAM_GAP_EN to insert GAP_CYCLES idle cycles between consecutive frames.
module fft_stream_source #(
  parameter int          DATA_W     = 32,
  parameter int          FRAME_LEN  = 256,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001,
  parameter logic [31:0] LFSR_TAPS  = 32'h8020_0003,
  parameter int          GAP_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_step,
  input  logic [CNT_W-1:0]  i_num_frames,
  input  logic              i_data_ready,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);
  localparam int                KW     = $clog2(FRAME_LEN);
  localparam logic [KW-1:0]     K_LAST = KW'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] SEED   = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] TAPS   = DATA_W'(LFSR_TAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef STREAM_GAP_EN
  localparam logic [1:0]    S_GAP  = 2'd2;
  localparam int            GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  logic [GW-1:0] gap_q, gap_d;
`endif

  logic [1:0]        state_q, state_d, mode_q, mode_d;
  logic [DATA_W-1:0] step_q, step_d, lfsr_q, lfsr_d, data_q, data_d, lfsr_adv;
  logic [CNT_W-1:0]  nfr_q, nfr_d, frm_q, frm_d;
  logic [KW-1:0]     k_q, k_d;
  logic              valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
  logic              xfer, frame_end, last_frame;

  // Sample for the slot being loaded; 'first' marks k == 0 of a frame.
  function automatic logic [DATA_W-1:0] pick(input logic [1:0] mode, input logic first,
                                             input logic [DATA_W-1:0] prev, step, lfsr);
    case (mode)
      2'd0:    return first ? '0 : prev + step;
      2'd1:    return step;
      2'd2:    return first ? step : '0;
      default: return lfsr;
    endcase
  endfunction

  assign lfsr_adv   = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  assign xfer       = valid_q && i_data_ready;
  assign frame_end  = (k_q == K_LAST);
  assign last_frame = (nfr_q != '0) && ((frm_q + CNT_W'(1)) == nfr_q);

  always_comb begin
    state_d = state_q; mode_d = mode_q; step_d = step_q; nfr_d = nfr_q; frm_d = frm_q;
    k_d = k_q; lfsr_d = lfsr_q; data_d = data_q; valid_d = valid_q; last_d = last_q;
    busy_d = busy_q; done_d = 1'b0;
`ifdef STREAM_GAP_EN
    gap_d = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A start on the o_done cycle is dropped so the run boundary stays clean.
        if (i_start && !done_q) begin
          mode_d  = i_mode; step_d = i_step; nfr_d = i_num_frames;
          frm_d   = '0; k_d = '0; lfsr_d = SEED;
          data_d  = pick(i_mode, 1'b1, '0, i_step, SEED);
          valid_d = 1'b1; last_d = 1'b0; busy_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          lfsr_d = lfsr_adv;
          data_d = pick(mode_q, frame_end, data_q, step_q, lfsr_adv);
          if (frame_end) begin
            frm_d  = frm_q + CNT_W'(1);
            k_d    = '0;
            last_d = 1'b0;
            if (last_frame) begin
              valid_d = 1'b0; busy_d = 1'b0; done_d = 1'b1;
              state_d = S_IDLE;
            end else begin
`ifdef STREAM_GAP_EN
              valid_d = 1'b0; gap_d = '0;
              state_d = S_GAP;
`else
              valid_d = 1'b1;
`endif
            end
          end else begin
            k_d    = k_q + KW'(1);
            last_d = ((k_q + KW'(1)) == K_LAST);
          end
        end
      end
`ifdef STREAM_GAP_EN
      S_GAP: begin
        if (gap_q == G_LAST) begin
          valid_d = 1'b1;
          state_d = S_RUN;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
`endif
      default: begin
        valid_d = 1'b0; last_d = 1'b0; busy_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE; mode_q <= '0; step_q <= '0; nfr_q <= '0; frm_q <= '0;
      k_q <= '0; lfsr_q <= SEED; data_q <= '0; valid_q <= 1'b0; last_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0;
`ifdef STREAM_GAP_EN
      gap_q <= '0;
`endif
    end else begin
      state_q <= state_d; mode_q <= mode_d; step_q <= step_d; nfr_q <= nfr_d; frm_q <= frm_d;
      k_q <= k_d; lfsr_q <= lfsr_d; data_q <= data_d; valid_q <= valid_d; last_q <= last_d;
      busy_q <= busy_d; done_q <= done_d;
`ifdef STREAM_GAP_EN
      gap_q <= gap_d;
`endif
    end
  end

  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_last       = last_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_fft_stream_source.sv
// Self-checking bench for fft_stream_source: table of runs against a sample-stream model,
// plus hand sequences for async reset mid-frame and continuous mode.
module tb_fft_stream_source;
  localparam int          DW   = 32;
  localparam int          FL   = 8;
  localparam int          CW   = 16;
  localparam int          GAP  = 4;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;
`ifdef STREAM_GAP_EN
  localparam int EXP_GAP = GAP;
`else
  localparam int EXP_GAP = 0;
`endif

  logic          i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_data_ready = 1'b0;
  logic [1:0]    i_mode = '0;
  logic [DW-1:0] i_step = '0;
  logic [CW-1:0] i_num_frames = '0;
  logic          o_data_valid, o_last, o_busy, o_done;
  logic [DW-1:0] o_data;

  fft_stream_source #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW), .LFSR_SEED(SEED),
                      .LFSR_TAPS(TAPS), .GAP_CYCLES(GAP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
    .i_num_frames(i_num_frames), .i_data_ready(i_data_ready), .o_data_valid(o_data_valid),
    .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_done(o_done));

  always #5 i_clk = ~i_clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] step;
    int          nfr;
    int          rmode;      // 0 ready high, 1 toggle, 2 random
    int          exp_xfers;
  } vec_t;

  vec_t        tbl[7];
  logic [31:0] expq[$];

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Expected stream of a whole run straight from the pattern definitions.
  task automatic build(input logic [1:0] mode, input logic [31:0] step, input int nfr);
    logic [31:0] l;
    l = SEED;
    expq.delete();
    for (int f = 0; f < nfr; f++)
      for (int k = 0; k < FL; k++) begin
        case (mode)
          2'd0: expq.push_back(32'(step * 32'(k)));
          2'd1: expq.push_back(step);
          2'd2: expq.push_back((k == 0) ? step : 32'd0);
          default: begin expq.push_back(l); l = galois(l); end
        endcase
      end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int total, n, cyc, gaps;
    logic hold, hl, rdy;
    logic [31:0] hd;
    total = v.nfr * FL; n = 0; cyc = 0; gaps = 0; hold = 1'b0; hl = 1'b0; hd = '0;
    build(v.mode, v.step, v.nfr);
    i_mode = v.mode; i_step = v.step; i_num_frames = CW'(v.nfr); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), o_busy, 1);
    chk($sformatf("v%0d valid_after_start", idx), o_data_valid, 1);
    while (n < total && cyc < 1000) begin
      case (v.rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_data_ready = rdy;
      i_start = (cyc == 5);
      if (hold) begin
        chk($sformatf("v%0d hold_valid", idx), o_data_valid, 1);
        chk($sformatf("v%0d hold_data", idx), o_data, hd);
        chk($sformatf("v%0d hold_last", idx), o_last, hl);
      end
      if (o_data_valid && rdy) begin
        chk($sformatf("v%0d data[%0d]", idx, n), o_data, expq[n]);
        chk($sformatf("v%0d last[%0d]", idx, n), o_last, (n % FL) == FL - 1);
        n++;
      end else if (!o_data_valid) begin
        gaps++;
        chk($sformatf("v%0d last_in_gap", idx), o_last, 0);
      end
      hold = o_data_valid && !rdy; hd = o_data; hl = o_last;
      @(negedge i_clk);
      cyc++;
    end
    i_start = 1'b0;
    chk($sformatf("v%0d xfers", idx), 64'(n), 64'(v.exp_xfers));
    chk($sformatf("v%0d gap_cycles", idx), 64'(gaps), 64'(EXP_GAP * (v.nfr - 1)));
    chk($sformatf("v%0d valid_end", idx), o_data_valid, 0);
    chk($sformatf("v%0d busy_end", idx), o_busy, 0);
    chk($sformatf("v%0d done_pulse", idx), o_done, 1);
    i_start = 1'b1;                      // coincident with o_done: must be ignored
    @(negedge i_clk);
    i_start = 1'b0;
    chk($sformatf("v%0d done_clear", idx), o_done, 0);
    chk($sformatf("v%0d start_on_done_ignored", idx), o_busy, 0);
    i_data_ready = 1'b0;
  endtask

  initial begin
    int cyc, n;
    tbl[0] = '{mode: 2'd0, step: 32'd1,          nfr: 2, rmode: 0, exp_xfers: 16};
    tbl[1] = '{mode: 2'd0, step: 32'hFFFF_FFFF,  nfr: 1, rmode: 2, exp_xfers: 8};
    tbl[2] = '{mode: 2'd2, step: 32'd5,          nfr: 2, rmode: 1, exp_xfers: 16};
    tbl[3] = '{mode: 2'd3, step: 32'd0,          nfr: 1, rmode: 0, exp_xfers: 8};
    tbl[4] = '{mode: 2'd3, step: 32'd0,          nfr: 1, rmode: 2, exp_xfers: 8};
    tbl[5] = '{mode: 2'd1, step: 32'hDEAD_BEEF,  nfr: 3, rmode: 2, exp_xfers: 24};
    tbl[6].mode = 2'($urandom_range(0, 3));
    tbl[6].step = $urandom;
    tbl[6].nfr = 2; tbl[6].rmode = 2; tbl[6].exp_xfers = 16;

    repeat (2) @(negedge i_clk);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_valid", o_data_valid, 0);
    chk("idle_busy", o_busy, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Async reset mid-frame at sample 3, then a clean restart.
    i_mode = 2'd0; i_step = 32'd1; i_num_frames = 16'd1; i_data_ready = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0;
    while (!(o_data_valid && o_data == 32'd3) && cyc < 50) begin @(negedge i_clk); cyc++; end
    chk("reach_sample3", o_data, 3);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_data_valid, 0);
    chk("arst_data", o_data, 0);
    chk("arst_last", o_last, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_step = 32'd7; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("restart_busy", o_busy, 1);
    chk("restart_valid", o_data_valid, 1);
    chk("restart_data0", o_data, 0);
    @(negedge i_clk);
    chk("restart_data1", o_data, 7);
    cyc = 0;
    while (o_busy && cyc < 50) begin @(negedge i_clk); cyc++; end
    chk("restart_finished", o_busy, 0);
    @(negedge i_clk);

    // Continuous mode: no o_done, ramp restarts each frame.
    i_mode = 2'd0; i_step = 32'd3; i_num_frames = '0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      i_data_ready = 1'($urandom_range(0, 1));
      chk("cont_no_done", o_done, 0);
      if (o_data_valid && i_data_ready) begin
        chk($sformatf("cont_data[%0d]", n), o_data, 32'(3 * (n % FL)));
        n++;
      end
      @(negedge i_clk);
    end
    chk("cont_still_busy", o_busy, 1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
